// File: rtl/seq_restoring_div.sv
// rtl/seq_restoring_div.sv - sequential radix-2 restoring unsigned divider
// One quotient bit per clock; divide-by-zero short-circuits straight to DONE.
module seq_restoring_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             keep;
  logic             last;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] work_nxt;

  // work holds the dividend bits still to be consumed; quotient bits shift in behind them
  always_comb begin
    shifted  = {prem, work[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    keep     = ~trial[WIDTH];
    prem_nxt = keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    work_nxt = {work[WIDTH-2:0], keep};
    last     = (cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dvs       <= '0;
      work      <= '0;
      prem      <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
            end else begin
              work <= dividend;
              dvs  <= divisor;
              prem <= '0;
              cnt  <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          work <= work_nxt;
          prem <= prem_nxt;
          cnt  <= cnt - CW'(1);
          // visible results only move on the final step so they hold steady during CALC
          if (last) begin
            quotient  <= work_nxt;
            remainder <= prem_nxt;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_restoring_div.md
SEQ_RESTORING_DIV -- requirements
Module: seq_restoring_div

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request pulse; sampled on clk rising edge.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator; sampled with start.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress (not IDLE).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag for the last completed request.

Function
REQ-012 SHALL implement an FSM with exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and divisor!=0 at edge k -> load dividend/divisor, clear partial remainder, set iteration counter to WIDTH, go CALC.
REQ-014 IDLE: start=1 and divisor==0 at edge k -> go DONE directly; quotient = all ones, remainder = dividend, dbz=1, registered at edge k.
REQ-015 CALC: one radix-2 restoring step per edge (shift in next dividend MSB, trial subtract on WIDTH+1 bits, keep on non-negative, quotient bit = 1 on keep, else 0).
REQ-016 CALC SHALL last exactly WIDTH edges (k+1 .. k+WIDTH); final quotient/remainder/dbz=0 registered at edge k+WIDTH, state -> DONE.
REQ-017 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-018 Latency: done high in the cycle after edge k+WIDTH (normal) or after edge k (divide-by-zero).
REQ-019 busy SHALL be 1 in CALC and DONE, 0 in IDLE; derived from state register, no combinational path from start.
REQ-020 start while busy=1 (CALC or DONE) SHALL be ignored; operand inputs SHALL not affect an in-flight division.
REQ-021 quotient, remainder, dbz SHALL hold their last values from done until the next completion or reset; they SHALL not change during CALC.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for every divisor != 0 (exact, no approximation).
REQ-023 Boundary: dividend < divisor -> quotient 0, remainder = dividend; divisor 1 -> quotient = dividend, remainder 0; dividend 0 -> quotient 0, remainder 0.
REQ-024 Back-to-back: start asserted in the cycle immediately after done (state IDLE) SHALL be accepted.

Reset
REQ-025 rst=1 SHALL immediately (without clk) force state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, dbz=0, internal datapath 0.
REQ-026 rst asserted mid-CALC SHALL abort the division; no done pulse SHALL be produced for it.
REQ-027 start sampled while rst=1 SHALL be ignored; first accepted start is on the first edge with rst=0.

Verification
REQ-028 WIDTH=8, start at edge k with 100/7 -> busy 1 from edge k, done pulse in cycle after edge k+8, quotient=14, remainder=2, dbz=0.
REQ-029 5/0 -> done in cycle after edge k, quotient=255, remainder=5, dbz=1; then 255/1 -> quotient=255, remainder=0, dbz=0.
REQ-030 3/200 -> quotient=0, remainder=3; 0/9 -> quotient=0, remainder=0.
REQ-031 start 100/7, then start 50/5 at edge k+3 -> second ignored; result 14 r 2; single done pulse.
REQ-032 start 200/3, rst pulsed at edge k+4 (async, mid-cycle) -> all outputs 0 immediately, no done; next start 200/3 -> 66 r 2.
REQ-033 Random sweep of all 65536 operand pairs (WIDTH=8), back-to-back starts -> REQ-022 holds, done count equals accepted start count.
